hht_control: RTL and testbench

- Sequencer for the 16x16 HHT datapath. Walks a compressed column stream in word memory 1 and fetches per-column vector values from word memory 2.
- Accumulates a binary-sparse-matrix × vector product into an internal result bank: y[row] += v[col] for every (row, col) entry in the stream.
- Drives two read-address buses into external combinational memories (data returns in the same cycle). Results stay in internal registers for hierarchical inspection.

---
 rtl/hht_control.sv | 155 +++++++++++++++
 tb/tb_hht_control.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hht_control.sv
// hht_control: sequencer for the 16x16 HHT datapath.
//
// Walks a compressed column stream (memory 1) and fetches per-column vector
// values (memory 2). For every (row, col) entry in the stream it adds v[col]
// into the internal result register y[row]. Both memories are external and
// combinational: data for the address held this cycle is sampled at the next
// rising edge.
//
// Ports:
//   Clk            system clock, rising edge
//   Rst            synchronous reset, active-low
//   RD             run enable; high starts/continues, low pauses or rearms
//   v_values_base  word address of v[0]
//   wdata_col_base word address of the first column-stream word
//   csize          number of column-stream words to consume
//   dataIn1        read data for addr1 (column stream)
//   dataIn2        read data for addr2 (vector values)
//   addr1          registered read address into the column-stream memory
//   addr2          registered read address into the vector memory
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for RD; clears results and loads bases on start
// HDR   | consuming a record header (index count for current column)
// IDX   | consuming row-index words, accumulating vreg into y[row]
// DONE  | run finished; outputs and results hold until RD drops

module hht_control #(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         RD,
    input  logic [W-1:0] v_values_base,
    input  logic [W-1:0] wdata_col_base,
    input  logic [W-1:0] csize,
    input  logic [W-1:0] dataIn1,
    input  logic [W-1:0] dataIn2,
    output logic [W-1:0] addr1,
    output logic [W-1:0] addr2
);

    localparam int LG = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        IDX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0]  ptr;
    logic [W-1:0]  cnt;
    logic [W-1:0]  vreg;
    logic [LG-1:0] col;
    logic [W-1:0]  y [N];

    logic [W-1:0]  ptr_inc;
    logic [W-1:0]  cnt_dec;
    logic [LG-1:0] col_inc;
    logic          last_word;

    logic          start;
    logic          hdr_step;
    logic          idx_step;
    logic          col_adv;

    assign ptr_inc   = ptr + W'(1);
    assign cnt_dec   = cnt - W'(1);
    assign col_inc   = col + LG'(1);
    assign last_word = (ptr_inc == csize);

    // state register
    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (RD) state_nx = (csize == '0) ? DONE : HDR;
            HDR: begin
                if (RD) begin
                    if (last_word)           state_nx = DONE;
                    else if (dataIn1 == '0)  state_nx = HDR;
                    else                     state_nx = IDX;
                end
            end
            IDX: begin
                if (RD) begin
                    if (last_word)           state_nx = DONE;
                    else if (cnt_dec == '0)  state_nx = HDR;
                    else                     state_nx = IDX;
                end
            end
            DONE: if (!RD) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // control decode; RD low in HDR/IDX gates every step, which is the pause
    always_comb begin
        start    = (state == IDLE) && RD;
        hdr_step = (state == HDR)  && RD;
        idx_step = (state == IDX)  && RD;
        // column advances after an empty header or the last index of a record,
        // but not on the final stream word so addr2 holds in DONE
        col_adv  = (hdr_step && !last_word && (dataIn1 == '0)) ||
                   (idx_step && !last_word && (cnt_dec == '0));
    end

    // datapath registers
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            addr1 <= '0;
            addr2 <= '0;
            ptr   <= '0;
            cnt   <= '0;
            vreg  <= '0;
            col   <= '0;
            for (int i = 0; i < N; i++) y[i] <= '0;
        end else begin
            if (start) begin
                for (int i = 0; i < N; i++) y[i] <= '0;
                ptr   <= '0;
                col   <= '0;
                addr1 <= wdata_col_base;
                addr2 <= v_values_base;
            end
            if (hdr_step) begin
                cnt   <= dataIn1;
                vreg  <= dataIn2;
                ptr   <= ptr_inc;
                addr1 <= addr1 + W'(1);
            end
            if (idx_step) begin
                y[dataIn1[LG-1:0]] <= y[dataIn1[LG-1:0]] + vreg;
                cnt   <= cnt_dec;
                ptr   <= ptr_inc;
                addr1 <= addr1 + W'(1);
            end
            if (col_adv) begin
                col   <= col_inc;
                addr2 <= v_values_base + W'(col_inc);
            end
        end
    end

endmodule

// File: tb/tb_hht_control.sv
// Directed bench for hht_control: external combinational memories, checks
// taken on the falling edge, results read hierarchically from the DUT.

module tb_hht_control;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RD;
    logic [31:0] v_values_base;
    logic [31:0] wdata_col_base;
    logic [31:0] csize;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [31:0] addr1;
    logic [31:0] addr2;

    logic [31:0] mem1 [512];
    logic [31:0] mem2 [512];
    logic [31:0] yexp [16];

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    hht_control #(.N(16), .W(32)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .RD            (RD),
        .v_values_base (v_values_base),
        .wdata_col_base(wdata_col_base),
        .csize         (csize),
        .dataIn1       (dataIn1),
        .dataIn2       (dataIn2),
        .addr1         (addr1),
        .addr2         (addr2)
    );

    always_comb begin
        dataIn1 = (addr1 < 32'd512) ? mem1[addr1[8:0]] : 32'd0;
        dataIn2 = (addr2 < 32'd512) ? mem2[addr2[8:0]] : 32'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_y(input string tag, input int row, input logic [31:0] exp);
        check($sformatf("%s_y%0d", tag, row), dut.y[row], exp);
    endtask

    task automatic check_y_model(input string tag);
        for (int i = 0; i < 16; i++) check_y(tag, i, yexp[i]);
    endtask

    // record-level reference: walk headers and indices, truncate at cs words
    task automatic build_model(input int base, input int vb, input int cs);
        int p;
        int c;
        int h;
        logic [31:0] v;
        logic [31:0] w;
        for (int i = 0; i < 16; i++) yexp[i] = 0;
        p = 0;
        c = 0;
        while (p < cs) begin
            h = int'(mem1[base + p]);
            v = mem2[vb + c];
            p++;
            for (int j = 0; j < h && p < cs; j++) begin
                w = mem1[base + p];
                yexp[w[3:0]] = yexp[w[3:0]] + v;
                p++;
            end
            c = (c + 1) % 16;
        end
    endtask

    initial begin
        int p;
        int k;
        int h;
        int row;
        for (int i = 0; i < 512; i++) begin
            mem1[i] = 32'd0;
            mem2[i] = 32'd0;
        end
        // record 0 at 180: header 7
        mem1[180] = 7;
        mem1[181] = 14; mem1[182] = 8; mem1[183] = 15; mem1[184] = 4;
        mem1[185] = 5;  mem1[186] = 2; mem1[187] = 5;
        // record 1 at 188: header 14, rows 0..13
        mem1[188] = 14;
        for (int j = 0; j < 14; j++) mem1[189 + j] = j;
        // filler records with junk upper bits on index words and some empty headers
        p = 203;
        k = 2;
        while (p < 400) begin
            h = (k * 5) % 7;
            mem1[p] = h;
            p++;
            for (int j = 0; j < h && p < 400; j++) begin
                row = (k * 3 + j * 5) % 16;
                mem1[p] = 32'(row) | (32'(j + 1) << 8);
                p++;
            end
            k++;
        end
        for (int c = 0; c < 16; c++) mem2[2 + c] = 32'(c * 1000 + 7);
        mem2[2] = 84;
        mem2[3] = 49;
        // zero-header stream
        mem1[400] = 0; mem1[401] = 2; mem1[402] = 3; mem1[403] = 1; mem1[404] = 7;
        mem2[20] = 5; mem2[21] = 9; mem2[22] = 77;

        Rst = 1'b0;
        RD = 1'b0;
        v_values_base = 2;
        wdata_col_base = 180;
        csize = 205;
        tick(2);
        Rst = 1'b1;
        check("rst_addr1", addr1, 0);
        check("rst_addr2", addr2, 0);
        check("rst_state", 32'(dut.state), 0);
        check_y("rst", 5, 0);

        // full run with per-record checkpoints
        RD = 1'b1;
        tick(1);
        check("start_state", 32'(dut.state), 1);
        check("start_addr1", addr1, 180);
        check("start_addr2", addr2, 2);
        tick(8);
        check_y("rec0", 5, 168);
        check_y("rec0", 2, 84);
        check_y("rec0", 4, 84);
        check_y("rec0", 8, 84);
        check_y("rec0", 14, 84);
        check_y("rec0", 15, 84);
        check_y("rec0", 0, 0);
        check("rec0_addr2", addr2, 3);
        check("rec0_addr1", addr1, 188);
        tick(15);
        check_y("rec1", 0, 49);
        check_y("rec1", 2, 133);
        check_y("rec1", 5, 217);
        check_y("rec1", 13, 49);
        check_y("rec1", 14, 84);
        check("rec1_addr2", addr2, 4);
        tick(181);
        check("full_not_done_205", 32'(dut.state == 2'd3), 0);
        tick(1);
        check("full_done_206", 32'(dut.state), 3);
        check("full_addr1", addr1, 385);
        build_model(180, 2, 205);
        check_y_model("full");
        tick(3);
        check("done_hold_state", 32'(dut.state), 3);
        check("done_hold_addr1", addr1, 385);

        // rerun after RD low
        RD = 1'b0;
        tick(1);
        check("rearm_state", 32'(dut.state), 0);
        RD = 1'b1;
        tick(1);
        check_y("rerun_clear", 5, 0);
        tick(205);
        check("rerun_done", 32'(dut.state), 3);
        check_y_model("rerun");

        // pause in the middle of record 0
        RD = 1'b0;
        tick(1);
        RD = 1'b1;
        tick(5);
        check("pre_pause_state", 32'(dut.state), 2);
        check("pre_pause_ptr", dut.ptr, 4);
        RD = 1'b0;
        tick(3);
        check("pause_state", 32'(dut.state), 2);
        check("pause_ptr", dut.ptr, 4);
        check("pause_addr1", addr1, 184);
        check("pause_addr2", addr2, 2);
        check_y("pause", 14, 84);
        check_y("pause", 8, 84);
        check_y("pause", 4, 0);
        RD = 1'b1;
        tick(200);
        check("pause_not_done", 32'(dut.state == 2'd3), 0);
        tick(1);
        check("pause_done", 32'(dut.state), 3);
        check_y_model("pause");

        // reset mid-run
        RD = 1'b0;
        tick(1);
        RD = 1'b1;
        tick(11);
        Rst = 1'b0;
        RD = 1'b0;
        tick(1);
        Rst = 1'b1;
        check("midrst_addr1", addr1, 0);
        check("midrst_addr2", addr2, 0);
        check("midrst_state", 32'(dut.state), 0);
        check("midrst_ptr", dut.ptr, 0);
        for (int i = 0; i < 16; i++) check_y("midrst", i, 0);

        // csize = 0 goes straight to DONE
        csize = 0;
        RD = 1'b1;
        tick(1);
        check("cs0_state", 32'(dut.state), 3);
        check("cs0_addr1", addr1, 180);
        RD = 1'b0;
        tick(1);

        // zero header, truncated at 4 words
        wdata_col_base = 400;
        v_values_base = 20;
        csize = 4;
        RD = 1'b1;
        tick(5);
        check("zh4_state", 32'(dut.state), 3);
        check_y("zh4", 3, 9);
        check_y("zh4", 1, 9);
        check_y("zh4", 7, 0);
        check_y("zh4", 0, 0);
        check("zh4_addr1", addr1, 404);
        check("zh4_addr2", addr2, 21);
        RD = 1'b0;
        tick(1);
        csize = 5;
        RD = 1'b1;
        tick(6);
        check("zh5_state", 32'(dut.state), 3);
        check_y("zh5", 3, 9);
        check_y("zh5", 1, 9);
        check_y("zh5", 7, 0);
        check("zh5_addr1", addr1, 405);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
